instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 86 ++++++++
 tb/tb_instr_fetch.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC and sequences reads from the 32x8 memory.
// Captures each word into ir and offers it to decode on valid/ready.
module instr_fetch #(
  parameter int AWIDTH   = 5,
  parameter int DWIDTH   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              load_pc,
  input  logic [AWIDTH-1:0] pc_in,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [2:0]        opcode,
  output logic [4:0]        operand,
  output logic [AWIDTH-1:0] instr_pc,
  output logic [AWIDTH-1:0] pc,
  output logic              mem_read,
  output logic              mem_write,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_data
);

  localparam logic [AWIDTH-1:0] PC0 = AWIDTH'(RESET_PC);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD
  } state_t;

  state_t            state;
  logic [DWIDTH-1:0] ir;

  // Read only when a fetch really goes ahead: a halt or a redirect in
  // FETCH cancels it, which also keeps reads from landing back to back.
  always_comb begin
    mem_read = (state == FETCH) && !halt && !load_pc && !rst;
  end

  assign mem_write = 1'b0;
  assign mem_addr  = pc;
  assign opcode    = ir[7:5];
  assign operand   = ir[4:0];

  // Fetch sequencer; a redirect overrides every state except reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= PC0;
      ir          <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (load_pc) begin
      pc          <= pc_in;
      instr_valid <= 1'b0;
      state       <= halt ? IDLE : FETCH;
    end else begin
      unique case (state)
        IDLE: begin
          if (!halt) state <= FETCH;
        end
        FETCH: begin
          state <= halt ? IDLE : WAIT;
        end
        WAIT: begin
          ir          <= mem_data;
          instr_pc    <= pc;
          pc          <= pc + 1'b1;
          instr_valid <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= halt ? IDLE : FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus a randomized run scored
// against a transaction-level model of the fetch address stream.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       halt = 1'b0;
  logic       load_pc = 1'b0;
  logic [4:0] pc_in = '0;
  logic       instr_ready = 1'b0;
  logic       instr_valid;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic [4:0] instr_pc;
  logic [4:0] pc;
  logic       mem_read;
  logic       mem_write;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;

  logic [7:0] mem [32];

  int tests = 0;
  int fails = 0;

  instr_fetch dut (
    .clk(clk), .rst(rst), .halt(halt), .load_pc(load_pc),
    .pc_in(pc_in), .instr_ready(instr_ready),
    .instr_valid(instr_valid), .opcode(opcode), .operand(operand),
    .instr_pc(instr_pc), .pc(pc), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // 32x8 synchronous memory, one-cycle registered read
  always @(posedge clk) begin
    if (mem_read) mem_data <= mem[mem_addr];
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    halt = 1'b0;
    load_pc = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s timeout: instr_valid=%b required 1", name, instr_valid);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++;
    if ({instr_valid, pc, instr_pc, opcode, operand, mem_read, mem_write}
        !== 21'd0) begin
      fails++;
      $display("FAIL reset: v=%b pc=%0d ipc=%0d op=%0d opd=%0d rd=%b wr=%b required all 0",
               instr_valid, pc, instr_pc, opcode, operand, mem_read, mem_write);
    end
  endtask

  task automatic test_sequential();
    logic [2:0] eop [3];
    logic [4:0] eopd [3];
    int idx = 0;
    eop[0] = 3'd5; eop[1] = 3'd2; eop[2] = 3'd7;
    eopd[0] = 5'd3; eopd[1] = 5'd1; eopd[2] = 5'd31;
    mem[0] = 8'hA3; mem[1] = 8'h41; mem[2] = 8'hFF;
    instr_ready = 1'b1;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      step();
      tests++;
      if (instr_valid !== (k % 3 == 0)) begin
        fails++;
        $display("FAIL seq_valid cycle %0d: got %b required %b",
                 k, instr_valid, (k % 3 == 0));
      end
      tests++;
      if (mem_read !== (k % 3 == 1)) begin
        fails++;
        $display("FAIL seq_read cycle %0d: got %b required %b",
                 k, mem_read, (k % 3 == 1));
      end
      if (k % 3 == 0) begin
        tests++;
        if ({opcode, operand, instr_pc} !== {eop[idx], eopd[idx], 5'(idx)}) begin
          fails++;
          $display("FAIL seq_fields %0d: got op=%0d opd=%0d ipc=%0d required %0d %0d %0d",
                   idx, opcode, operand, instr_pc, eop[idx], eopd[idx], idx);
        end
        idx++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [12:0] snap;
    instr_ready = 1'b0;
    do_reset();
    wait_valid("bp_wait");
    snap = {opcode, operand, instr_pc};
    for (int k = 0; k < 5; k++) begin
      step();
      tests++;
      if (!instr_valid || {opcode, operand, instr_pc} !== snap || mem_read) begin
        fails++;
        $display("FAIL bp_stable %0d: v=%b fields=%h rd=%b required 1 %h 0",
                 k, instr_valid, {opcode, operand, instr_pc}, mem_read, snap);
      end
    end
    instr_ready = 1'b1;
    step();
    tests++;
    if (mem_read !== 1'b1 || mem_addr !== 5'd1) begin
      fails++;
      $display("FAIL bp_resume: rd=%b addr=%0d required 1 1", mem_read, mem_addr);
    end
  endtask

  task automatic test_wrap();
    mem[31] = 8'h20;
    mem[0] = 8'h07;
    instr_ready = 1'b0;
    do_reset();
    load_pc = 1'b1;
    pc_in = 5'd31;
    step();
    load_pc = 1'b0;
    wait_valid("wrap_first");
    tests++;
    if ({instr_pc, opcode, operand, pc} !== {5'd31, 3'd1, 5'd0, 5'd0}) begin
      fails++;
      $display("FAIL wrap_first: ipc=%0d op=%0d opd=%0d pc=%0d required 31 1 0 0",
               instr_pc, opcode, operand, pc);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    wait_valid("wrap_second");
    tests++;
    if ({instr_pc, opcode, operand, pc} !== {5'd0, 3'd0, 5'd7, 5'd1}) begin
      fails++;
      $display("FAIL wrap_second: ipc=%0d op=%0d opd=%0d pc=%0d required 0 0 7 1",
               instr_pc, opcode, operand, pc);
    end
  endtask

  task automatic test_jump();
    instr_ready = 1'b1;
    do_reset();
    step();
    step();
    load_pc = 1'b1;
    pc_in = 5'd10;
    step();
    load_pc = 1'b0;
    tests++;
    if (instr_valid !== 1'b0 || pc !== 5'd10) begin
      fails++;
      $display("FAIL jump_redirect: v=%b pc=%0d required 0 10", instr_valid, pc);
    end
    wait_valid("jump_wait");
    tests++;
    if ({instr_pc, opcode, operand} !== {5'd10, mem[10]}) begin
      fails++;
      $display("FAIL jump_fields: ipc=%0d ir=%h required 10 %h",
               instr_pc, {opcode, operand}, mem[10]);
    end
  endtask

  task automatic test_halt();
    instr_ready = 1'b1;
    do_reset();
    step();
    step();
    halt = 1'b1;
    step();
    tests++;
    if (instr_valid !== 1'b1 || instr_pc !== 5'd0) begin
      fails++;
      $display("FAIL halt_deliver: v=%b ipc=%0d required 1 0", instr_valid, instr_pc);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      tests++;
      if (mem_read !== 1'b0 || instr_valid !== 1'b0 || pc !== 5'd1) begin
        fails++;
        $display("FAIL halt_park %0d: rd=%b v=%b pc=%0d required 0 0 1",
                 k, mem_read, instr_valid, pc);
      end
    end
    halt = 1'b0;
    instr_ready = 1'b0;
    wait_valid("halt_resume");
    tests++;
    if (instr_pc !== 5'd1 || {opcode, operand} !== mem[1]) begin
      fails++;
      $display("FAIL halt_resume_fields: ipc=%0d ir=%h required 1 %h",
               instr_pc, {opcode, operand}, mem[1]);
    end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    do_reset();
    wait_valid("rstmid_wait");
    rst = 1'b1;
    step();
    tests++;
    if (instr_valid !== 1'b0 || pc !== 5'd0 || mem_read !== 1'b0 ||
        {opcode, operand} !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid: v=%b pc=%0d rd=%b ir=%h required 0 0 0 00",
               instr_valid, pc, mem_read, {opcode, operand});
    end
    rst = 1'b0;
  endtask

  // Model: the delivered stream is mem[a], mem[a+1], ... from the last
  // redirect target; every issued read targets the next address owed.
  task automatic test_random();
    logic [4:0]  exp_pc = 5'd0;
    logic        prev_rd = 1'b0;
    logic        prev_hold = 1'b0;
    logic [12:0] prev_f = '0;
    int          deliv = 0;
    fill_mem();
    instr_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      halt = ($urandom_range(0, 9) == 0);
      instr_ready = ($urandom_range(0, 9) < 7);
      load_pc = ($urandom_range(0, 29) == 0);
      pc_in = 5'($urandom);
      #1;
      if (mem_write !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL rnd_write cycle %0d: got %b required 0", c, mem_write);
      end
      if (mem_read) begin
        tests++;
        if (prev_rd || halt || load_pc || mem_addr !== exp_pc) begin
          fails++;
          $display("FAIL rnd_read cycle %0d: prev=%b halt=%b ld=%b addr=%0d required 0 0 0 %0d",
                   c, prev_rd, halt, load_pc, mem_addr, exp_pc);
        end
      end
      if (prev_hold) begin
        tests++;
        if (!instr_valid || {opcode, operand, instr_pc} !== prev_f) begin
          fails++;
          $display("FAIL rnd_stable cycle %0d: v=%b fields=%h required 1 %h",
                   c, instr_valid, {opcode, operand, instr_pc}, prev_f);
        end
      end
      if (instr_valid && instr_ready) begin
        tests++;
        if (instr_pc !== exp_pc || {opcode, operand} !== mem[exp_pc]) begin
          fails++;
          $display("FAIL rnd_deliver cycle %0d: ipc=%0d ir=%h required %0d %h",
                   c, instr_pc, {opcode, operand}, exp_pc, mem[exp_pc]);
        end
        exp_pc = exp_pc + 5'd1;
        deliv++;
      end
      if (load_pc) exp_pc = pc_in;
      prev_rd = mem_read;
      prev_hold = instr_valid && !instr_ready && !load_pc;
      prev_f = {opcode, operand, instr_pc};
      step();
    end
    load_pc = 1'b0;
    halt = 1'b0;
    tests++;
    if (deliv < 200) begin
      fails++;
      $display("FAIL rnd_progress: delivered %0d required at least 200", deliv);
    end
  endtask

  initial begin
    fill_mem();
    step();
    test_reset();
    test_sequential();
    test_backpressure();
    test_wrap();
    test_jump();
    test_halt();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
